// File: rtl/apb_reg_completer.sv
// APB completer exposing a bank of 32-bit word registers with a read-only ID at index 0.
// Every transfer is stretched by a fixed number of wait states before a one-cycle response.
module apb_reg_completer #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [2:0]                     pprot,
    input  logic                           pnse,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           strb_q, strb_d;
    logic                    pready_q, pready_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pslverr_q, pslverr_d;
    logic [NUM_REGS-1:0]     wrPulse_q, wrPulse_d;
    logic [DATA_WIDTH-1:0]   regs_q [1:NUM_REGS-1];

    logic [ADDR_WIDTH-1:0]   xferAddr;
    logic                    xferWrite;
    logic [NB-1:0]           xferStrb;
    logic [7:0]              xferIdx;
    logic                    xferErr;
    logic [DATA_WIDTH-1:0]   rdMux;
    logic                    commit;
    logic [7:0]              commitIdx;
    logic                    unusedOk;

    assign unusedOk = ^{pprot, pnse, paddr, addr_q};

    // In IDLE the response may be produced straight from the setup phase (no wait
    // states), so decode the live bus there and the captured transfer otherwise.
    always_comb begin
        xferAddr  = (state_q == IDLE) ? paddr  : addr_q;
        xferWrite = (state_q == IDLE) ? pwrite : write_q;
        xferStrb  = (state_q == IDLE) ? pstrb  : strb_q;
        xferIdx   = xferAddr[9:2];
        xferErr   = (xferAddr[1:0] != 2'b00)
                  || ({1'b0, xferIdx} >= 9'(NUM_REGS))
                  || (xferWrite && (xferIdx == 8'd0))
                  || (!xferWrite && (xferStrb != '0));
        rdMux = '0;
        if (xferIdx == 8'd0) begin
            rdMux = ID_VALUE;
        end
        for (int k = 1; k < NUM_REGS; k++) begin
            if (xferIdx == 8'(k)) begin
                rdMux = regs_q[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!psel) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pready_d  = (state_d == RESP);
        pslverr_d = pready_d && xferErr;
        prdata_d  = (pready_d && !xferErr && !xferWrite) ? rdMux : '0;
    end

    // A write only lands if the requester is still in its access phase at the response edge.
    assign commit    = (state_q == RESP) && write_q && !pslverr_q && psel && penable;
    assign commitIdx = addr_q[9:2];

    always_comb begin
        wrPulse_d = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (commit && (commitIdx == 8'(k))) begin
                wrPulse_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            wrPulse_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            wrPulse_q <= wrPulse_d;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k < NUM_REGS; k++) begin
                if (commit && (commitIdx == 8'(k))) begin
                    for (int b = 0; b < NB; b++) begin
                        if (strb_q[b]) begin
                            regs_q[k][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        reg_out = '0;
        reg_out[DATA_WIDTH-1:0] = ID_VALUE;
        for (int k = 1; k < NUM_REGS; k++) begin
            reg_out[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
        end
    end

    assign pready   = pready_q;
    assign prdata   = prdata_q;
    assign pslverr  = pslverr_q;
    assign wr_pulse = wrPulse_q;

endmodule
